// File: rtl/cacc_pkg.sv
// Shared constants and arithmetic helpers for the CACC stripe accumulator.
// Latency: none (package only). Backpressure: not applicable.
// Optional feature macro: CACC_SAT_EN selects clamping instead of wrapping in acc_add().
package cacc_pkg;

  localparam int CACC_ATOMK_HALF = 8;
  localparam int CACC_RES_W      = 19;
  localparam int CACC_ACC_W      = 32;
  localparam int CACC_DEPTH      = 16;
  localparam int CACC_OUT_DEPTH  = 4;

  // mac2accu_pd bit positions
  localparam int PD_STRIPE_ST    = 0;
  localparam int PD_STRIPE_END   = 1;
  localparam int PD_CHANNEL_END  = 2;
  localparam int PD_LAYER_END    = 3;

  // acc_err bit positions
  localparam int ERR_POS_OVF      = 0;
  localparam int ERR_LEN_MISMATCH = 1;
  localparam int ERR_FIFO_OVF     = 2;

  function automatic logic [CACC_ACC_W-1:0] sext_res(input logic [CACC_RES_W-1:0] v);
    return {{(CACC_ACC_W-CACC_RES_W){v[CACC_RES_W-1]}}, v};
  endfunction

  // Signed add with one guard bit; out-of-range results clamp or wrap.
  function automatic logic [CACC_ACC_W-1:0] acc_add(input logic [CACC_ACC_W-1:0] a,
                                                    input logic [CACC_ACC_W-1:0] b);
    logic [CACC_ACC_W:0]   s;
    logic [CACC_ACC_W-1:0] r;
    s = {a[CACC_ACC_W-1], a} + {b[CACC_ACC_W-1], b};
`ifdef CACC_SAT_EN
    if (s[CACC_ACC_W] != s[CACC_ACC_W-1])
      r = s[CACC_ACC_W] ? {1'b1, {(CACC_ACC_W-1){1'b0}}} : {1'b0, {(CACC_ACC_W-1){1'b1}}};
    else
      r = s[CACC_ACC_W-1:0];
`else
    r = s[CACC_ACC_W-1:0];
`endif
    return r;
  endfunction

endpackage

// File: rtl/cacc_out_fifo.sv
// Synchronous FIFO holding finished atoms (+ layer_end tag) for the delivery path.
// Latency: a push is visible at o_dat/o_empty the cycle after it is written.
// Backpressure: o_full reported; a push while full is accepted only with a same-cycle pop.
// Ports: i_clk, i_rst (sync, active-high), i_push/i_dat write side,
//        i_pop read side, o_dat head entry, o_full/o_empty status.
module cacc_out_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dat   = r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_LAST) ? '0 : r_wr + PTR_ONE;
      if (w_pop)  r_rd <= (r_rd == PTR_LAST) ? '0 : r_rd + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_dat;
  end

endmodule

// File: rtl/cacc_stripe_accum.sv
// Sums CMAC partial-sum beats element-wise across stripes; releases atoms on the channel_end stripe.
// Latency: beat registered at edge N, accumulator write / FIFO push at edge N+1, out valid after N+1.
// Backpressure: none on input (one beat/cycle); output valid/ready, FIFO overflow drops and flags.
// Ports: nvdla_core_clk/nvdla_core_rst (sync, active-high); mac2accu_* input beat (pvld, mask,
//        data, pd); acc_out_* valid/ready atom output with layer_end tag; dp2reg_done pulse;
//        acc_err sticky flags. Macro CACC_SAT_EN: clamp sums instead of wrapping.
module cacc_stripe_accum
  import cacc_pkg::*;
#(
  parameter int ATOMK_HALF = CACC_ATOMK_HALF,
  parameter int DEPTH      = CACC_DEPTH,
  parameter int OUT_DEPTH  = CACC_OUT_DEPTH
) (
  input  logic                             nvdla_core_clk,
  input  logic                             nvdla_core_rst,
  input  logic                             mac2accu_pvld,
  input  logic [ATOMK_HALF-1:0]            mac2accu_mask,
  input  logic [ATOMK_HALF*CACC_RES_W-1:0] mac2accu_data,
  input  logic [8:0]                       mac2accu_pd,
  output logic                             acc_out_pvld,
  input  logic                             acc_out_prdy,
  output logic [ATOMK_HALF*CACC_ACC_W-1:0] acc_out_data,
  output logic                             acc_out_layer_end,
  output logic                             dp2reg_done,
  output logic [2:0]                       acc_err
);
  // Lane widths are fixed by the package arithmetic helpers.
  localparam int RESULT_WIDTH = CACC_RES_W;
  localparam int ACC_WIDTH    = CACC_ACC_W;
  localparam int DW = ATOMK_HALF * ACC_WIDTH;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = IW + 1;                  // position may reach DEPTH (overflow)
  localparam logic [PW-1:0] POS_LIM = PW'(DEPTH);
  localparam logic [PW-1:0] POS_ONE = PW'(1);

  // ---------------- stage 0: register beat, apply mask, sign-extend ----------------
  logic          r_s0_vld;
  logic [DW-1:0] r_s0_dat;
  logic [3:0]    r_s0_pd;
  logic [DW-1:0] w_s0_dat;
  logic          w_unused_pd;

  assign w_unused_pd = ^mac2accu_pd[8:4];

  always_comb begin
    w_s0_dat = '0;
    for (int i = 0; i < ATOMK_HALF; i++) begin
      if (mac2accu_mask[i])
        w_s0_dat[i*ACC_WIDTH +: ACC_WIDTH] = sext_res(mac2accu_data[i*RESULT_WIDTH +: RESULT_WIDTH]);
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_s0_vld <= 1'b0;
      r_s0_dat <= '0;
      r_s0_pd  <= '0;
    end else begin
      r_s0_vld <= mac2accu_pvld;
      r_s0_dat <= w_s0_dat;
      r_s0_pd  <= mac2accu_pd[3:0];
    end
  end

  // ---------------- stage 1: position, accumulate, write back or push ----------------
  logic          w_st, w_se, w_ce, w_le;
  logic [PW-1:0] r_pos, r_len, w_pos, w_len;
  logic          r_first;
  logic [2:0]    r_err;
  logic          r_done;
  logic          w_ovf;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_old, w_sum;
  logic [DW-1:0] r_acc [DEPTH];

  assign w_st = r_s0_pd[PD_STRIPE_ST];
  assign w_se = r_s0_pd[PD_STRIPE_END];
  assign w_ce = r_s0_pd[PD_CHANNEL_END];
  assign w_le = r_s0_pd[PD_LAYER_END];

  // Counter saturates at DEPTH so a long stripe keeps reporting overflow instead of wrapping.
  assign w_pos = w_st ? '0 : ((r_pos == POS_LIM) ? r_pos : r_pos + POS_ONE);
  assign w_len = w_pos + POS_ONE;
  assign w_ovf = (w_pos >= POS_LIM);
  assign w_idx = w_pos[IW-1:0];
  // Read-add-write completes within one cycle, so a back-to-back beat at the same
  // position (length-1 stripes) already sees the previous sum: this is the forward path.
  assign w_old = r_acc[w_idx];

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < ATOMK_HALF; i++) begin
      w_sum[i*ACC_WIDTH +: ACC_WIDTH] =
        acc_add(r_first ? '0 : w_old[i*ACC_WIDTH +: ACC_WIDTH], r_s0_dat[i*ACC_WIDTH +: ACC_WIDTH]);
    end
  end

  // Channel_end sums go out, not back: the next group's first stripe overwrites the entry.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst && r_s0_vld && !w_ovf && !w_ce)
      r_acc[w_idx] <= w_sum;
  end

  // ---------------- output FIFO ----------------
  logic          w_push_req, w_push, w_pop, w_full, w_empty;
  logic [DW:0]   w_head;

  assign w_push_req = r_s0_vld & ~w_ovf & w_ce;
  assign w_pop      = acc_out_pvld & acc_out_prdy;
  assign w_push     = w_push_req & (~w_full | w_pop);

  cacc_out_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .i_clk   (nvdla_core_clk),
    .i_rst   (nvdla_core_rst),
    .i_push  (w_push),
    .i_dat   ({w_le, w_sum}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head is gated so outputs read zero (not stale memory) whenever nothing is valid.
  assign acc_out_pvld      = ~w_empty;
  assign acc_out_data      = w_empty ? '0 : w_head[DW-1:0];
  assign acc_out_layer_end = ~w_empty & w_head[DW];

  // ---------------- control state and flags ----------------
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_pos   <= '0;
      r_len   <= '0;
      r_first <= 1'b1;
      r_err   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_pop & w_head[DW];
      if (r_s0_vld) begin
        r_pos <= w_pos;
        if (w_ovf) r_err[ERR_POS_OVF] <= 1'b1;
        if (w_se) begin
          r_len <= w_len;
          // Only later stripes of a group are compared; the group's first stripe sets len.
          if (!r_first && (r_len != w_len)) r_err[ERR_LEN_MISMATCH] <= 1'b1;
          r_first <= w_ce;
        end
      end
      if (w_push_req && w_full && !w_pop) r_err[ERR_FIFO_OVF] <= 1'b1;
    end
  end

  assign dp2reg_done = r_done;
  assign acc_err     = r_err;

endmodule

// File: tb/tb_cacc_stripe_accum.sv
// Directed bench for cacc_stripe_accum with a stripe-level behavioural model and per-cycle checker.
// Latency: n/a. Backpressure: acc_out_prdy driven by the stimulus.
// Ports: none (top-level bench).
module tb_cacc_stripe_accum;
  localparam int NL = 8;
  localparam int RW = 19;
  localparam int AW = 32;
  localparam int DW = NL * AW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_vld = 1'b0;
  logic [NL-1:0]    in_mask = '0;
  logic [NL*RW-1:0] in_dat = '0;
  logic [8:0]       in_pd = '0;
  logic             out_vld;
  logic             out_rdy = 1'b1;
  logic [DW-1:0]    out_dat;
  logic             out_le;
  logic             done;
  logic [2:0]       err;

  always #5 clk = ~clk;

  cacc_stripe_accum dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .mac2accu_pvld     (in_vld),
    .mac2accu_mask     (in_mask),
    .mac2accu_data     (in_dat),
    .mac2accu_pd       (in_pd),
    .acc_out_pvld      (out_vld),
    .acc_out_prdy      (out_rdy),
    .acc_out_data      (out_dat),
    .acc_out_layer_end (out_le),
    .dp2reg_done       (done),
    .acc_err           (err)
  );

  int total = 0;
  int bad = 0;
  int n_done = 0;

  // Model state: per-position running sums of the current channel group.
  longint        m_acc [16][NL];
  bit            m_first;
  int            m_len;
  logic [2:0]    m_err;
  logic [DW-1:0] exp_d_q [$];
  logic          exp_le_q [$];
  logic [DW-1:0] got_q [$];

  function automatic longint red(input longint s);
    logic signed [31:0] t;
`ifdef CACC_SAT_EN
    if (s > 64'sd2147483647) return 64'sd2147483647;
    if (s < -64'sd2147483648) return -64'sd2147483648;
    return s;
`else
    t = s[31:0];
    return longint'(t);
`endif
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_first = 1'b1;
    m_len = 0;
    m_err = '0;
    exp_d_q.delete();
    exp_le_q.delete();
  endtask

  // One stripe of nb beats; lane value = base + b*inc (lane0 v0, lane1 v1, others vr).
  task automatic send_stripe(input int nb, input int v0, input int v1, input int vr, input int inc,
                             input logic [NL-1:0] mask, input bit ce, input bit le_last,
                             input bit chk_lat);
    logic [DW-1:0]    ed;
    logic [NL*RW-1:0] dv;
    int               v;
    longint           d;
    longint           s;
    for (int b = 0; b < nb; b++) begin
      ed = '0;
      dv = '0;
      for (int i = 0; i < NL; i++) begin
        v = ((i == 0) ? v0 : (i == 1) ? v1 : vr) + b * inc;
        dv[i*RW +: RW] = RW'(v);
        d = mask[i] ? longint'(v) : 64'sd0;
        if (b < 16) begin
          s = m_first ? d : red(m_acc[b][i] + d);
          if (ce) ed[i*AW +: AW] = s[31:0];
          else    m_acc[b][i] = s;
        end
      end
      if (b >= 16) m_err[0] = 1'b1;
      else if (ce) begin
        if (!out_rdy && exp_d_q.size() >= 4) m_err[2] = 1'b1;
        else begin
          exp_d_q.push_back(ed);
          exp_le_q.push_back(le_last && (b == nb - 1));
        end
      end
      in_vld  = 1'b1;
      in_mask = mask;
      in_dat  = dv;
      in_pd   = {5'b0, (le_last && (b == nb - 1)), ce, (b == nb - 1), (b == 0)};
      @(posedge clk); #1;
      if (chk_lat && b == 0) chk("latency_beat0", out_vld, 0);
      if (chk_lat && b == 1) chk("latency_beat1", out_vld, 1);
    end
    if (!m_first && m_len != nb) m_err[1] = 1'b1;
    m_len = nb;
    m_first = ce;
    in_vld = 1'b0;
  endtask

  task automatic raw_beat(input int val, input logic [8:0] pd);
    in_vld  = 1'b1;
    in_mask = '1;
    for (int i = 0; i < NL; i++) in_dat[i*RW +: RW] = RW'(val);
    in_pd = pd;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    in_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_d_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_d_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d atoms outstanding expected 0", exp_d_q.size());
    end
    idle(2);
    chk("empty_after_drain", out_vld, 0);
  endtask

  task automatic do_reset(input bit chk_outs);
    rst = 1'b1;
    @(posedge clk); #1;
    if (chk_outs) begin
      chk("rst_pvld", out_vld, 0);
      chk("rst_data", out_dat, 0);
      chk("rst_layer_end", out_le, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
    end
    rst = 1'b0;
    in_vld = 1'b0;
    model_reset();
  endtask

  // Per-cycle checker: popped atoms vs model, done pulse, hold stability under backpressure.
  logic          hold_v;
  logic [DW-1:0] hold_d;
  logic          hold_le;
  logic          exp_done;
  logic [DW-1:0] cmp_d;
  logic          cmp_le;

  always @(negedge clk) begin
    if (rst) begin
      hold_v   = 1'b0;
      exp_done = 1'b0;
    end else begin
      chk("done_pulse", done, exp_done);
      if (done) n_done++;
      exp_done = 1'b0;
      if (hold_v) begin
        chk("hold_pvld", out_vld, 1);
        chk("hold_data", out_dat, hold_d);
        chk("hold_layer_end", out_le, hold_le);
      end
      if (out_vld && out_rdy) begin
        if (exp_d_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_atom: got %h expected none", out_dat);
        end else begin
          cmp_d  = exp_d_q.pop_front();
          cmp_le = exp_le_q.pop_front();
          chk("atom_data", out_dat, cmp_d);
          chk("atom_layer_end", out_le, cmp_le);
          exp_done = cmp_le;
        end
        got_q.push_back(out_dat);
      end
      hold_v  = out_vld && !out_rdy;
      hold_d  = out_dat;
      hold_le = out_le;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] a;
  logic [DW-1:0] e;

  initial begin
    model_reset();
    // Reset values
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset(1'b1);

    // Basic accumulation: 3 stripes x 4 beats of 5 -> every lane 15
    got_q.delete();
    send_stripe(4, 5, 5, 5, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_stripe(4, 5, 5, 5, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_stripe(4, 5, 5, 5, 0, 8'hFF, 1'b1, 1'b0, 1'b1);
    drain();
    chk("basic_count", got_q.size(), 4);
    e = {NL{32'd15}};
    for (int k = 0; k < 4 && k < got_q.size(); k++) chk("basic_atom15", got_q[k], e);
    chk("basic_err", err, m_err);

    // Mask and sign: lane0 masked, lane1 = -3, len 2, two stripes
    got_q.delete();
    send_stripe(2, 100, -3, 1, 0, 8'hFE, 1'b0, 1'b0, 1'b0);
    send_stripe(2, 100, -3, 1, 0, 8'hFE, 1'b1, 1'b0, 1'b0);
    drain();
    a = (got_q.size() > 0) ? got_q[0] : '0;
    chk("mask_lane0", a[31:0], 32'd0);
    chk("mask_lane1", a[63:32], 32'hFFFF_FFFA);
    chk("mask_lane2", a[95:64], 32'd2);

    // Done pulse: layer_end on the final atom of a single-stripe group
    n_done = 0;
    send_stripe(2, 1, 2, 3, 1, 8'hFF, 1'b1, 1'b1, 1'b0);
    drain();
    idle(3);
    chk("done_count", n_done, 1);

    // Backpressure: 6-beat channel_end stripe into a 4-entry FIFO
    got_q.delete();
    out_rdy = 1'b0;
    send_stripe(6, 10, 20, 30, 100, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("bp_pvld_held", out_vld, 1);
    chk("bp_err_model", err, m_err);
    chk("bp_err_lit", err, 3'b100);
    out_rdy = 1'b1;
    drain();
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      a = got_q[k];
      chk("bp_lane0", a[31:0], 32'(10 + 100 * k));
      chk("bp_lane1", a[63:32], 32'(20 + 100 * k));
    end
    do_reset(1'b0);

    // Position overflow: 17-beat stripe
    send_stripe(17, 1, 1, 1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("ovf_err_model", err, m_err);
    chk("ovf_err_lit", err, 3'b001);
    do_reset(1'b0);

    // Stripe length mismatch: 4 then 3 in one group
    send_stripe(4, 1, 1, 1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_stripe(3, 1, 1, 1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("len_err_model", err, m_err);
    chk("len_err_lit", err, 3'b010);
    do_reset(1'b0);

    // Mid-stripe reset with atoms waiting in the FIFO, then a fresh group overwrites
    send_stripe(4, 7, 7, 7, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    out_rdy = 1'b0;
    raw_beat(9, 9'b0_0000_0101);
    raw_beat(9, 9'b0_0000_0100);
    idle(2);
    chk("mid_pvld_before_rst", out_vld, 1);
    in_vld = 1'b1;
    in_pd  = 9'b0_0000_0100;
    do_reset(1'b1);
    out_rdy = 1'b1;
    got_q.delete();
    send_stripe(4, 2, 2, 2, 0, 8'hFF, 1'b1, 1'b0, 1'b0);
    drain();
    chk("mid_count", got_q.size(), 4);
    e = {NL{32'd2}};
    a = (got_q.size() > 0) ? got_q[0] : '0;
    chk("mid_overwrite", a, e);

    // Saturation / wrap: 2^14 single-beat stripes of 2^18-1 on lane 0
    do_reset(1'b0);
    got_q.delete();
    for (int s = 0; s < 16384; s++)
      send_stripe(1, 262143, 0, 0, 0, 8'hFF, (s == 16383), 1'b0, 1'b0);
    drain();
    a = (got_q.size() > 0) ? got_q[0] : '0;
`ifdef CACC_SAT_EN
    chk("sat_lane0", a[31:0], 32'h7FFF_FFFF);
`else
    chk("wrap_lane0", a[31:0], 32'hFFFF_C000);
`endif
    chk("sat_lane1", a[63:32], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacc_stripe_accum.md
# cacc_stripe_accum

Accumulation stage that consumes the CMAC core's per-cycle partial sums (`mac2accu_*`) and sums them element-wise across successive stripes into a per-position accumulator buffer. On the channel-end stripe it releases finished atoms through a valid/ready output FIFO toward the CACC delivery path. It sits directly downstream of the CMAC core. The input has no backpressure, so every input beat is absorbed in one cycle or flagged.

## Interface
- `ATOMK_HALF`, 8, output lanes per beat.
- `RESULT_WIDTH`, 19, signed width of each incoming partial sum.
- `ACC_WIDTH`, 32, signed accumulator width per lane.
- `DEPTH`, 16, maximum atoms per stripe (accumulator entries).
- `OUT_DEPTH`, 4, output FIFO entries.

Ports:
- `nvdla_core_clk` in 1: the single clock.
- `nvdla_core_rst` in 1: reset, synchronous, active-high.
- `mac2accu_pvld` in 1: input beat valid; no ready.
- `mac2accu_mask` in ATOMK_HALF: per-lane valid; a masked lane contributes 0.
- `mac2accu_data` in ATOMK_HALF*RESULT_WIDTH: lane i at bits [i*RESULT_WIDTH +: RESULT_WIDTH], signed.
- `mac2accu_pd` in 9: [0] stripe_st, [1] stripe_end, [2] channel_end, [3] layer_end, [8:4] ignored.
- `acc_out_pvld` out 1: output atom valid.
- `acc_out_prdy` in 1: downstream ready.
- `acc_out_data` out ATOMK_HALF*ACC_WIDTH: finished atom.
- `acc_out_layer_end` out 1: marks the last atom of the layer.
- `dp2reg_done` out 1: one-cycle pulse.
- `acc_err` out 3: sticky flags. [0] position overflow, [1] stripe-length mismatch, [2] output FIFO overflow.

## Operation
- **Stage 0** registers pvld, mask-applied data (masked lanes forced to 0, then sign-extended to ACC_WIDTH), and pd.
- **Position counter `pos`:**
  - A beat with stripe_st sets the beat's position to 0.
  - Otherwise the position is the previous value + 1.
  - `pos` holds between beats.
- **First-stripe flag `first`:**
  - Set at reset and after every channel_end stripe completes.
  - While set, a beat overwrites `acc[pos]` with its data.
  - Otherwise the beat adds: `acc[pos] + data`.
  - `first` clears on the stripe_end beat of a non-channel_end stripe.
- **Stripe length:**
  - The stripe_end beat latches `len = pos+1`.
  - A later stripe in the same channel group whose stripe_end occurs at a different `pos+1` sets `acc_err[1]`.
  - Data is still processed.
- **Position overflow:** a beat at position ≥ DEPTH sets `acc_err[0]`. The beat is discarded: no write, no output.
- **Channel_end stripe:** each beat's final sum is pushed into the output FIFO, not written back. Its `acc` entry becomes don't-care, because the next stripe overwrites it.
- **FIFO full:**
  - If the FIFO is full when a push is required, the push is dropped and `acc_err[2]` is set.
  - A simultaneous pop in that cycle frees a slot, and the push succeeds.
- **Layer end:** layer_end carried on a channel_end beat tags that FIFO entry. `dp2reg_done` pulses the cycle after that entry is popped (`acc_out_pvld & acc_out_prdy`).
- **Write-read forwarding:** when consecutive beats hit the same `pos` (stripe length 1), the stage-1 sum forwards into the next add.
- **Arithmetic:** signed add at ACC_WIDTH+1 bits, then reduced to ACC_WIDTH per the Configuration section.
- **Reset:**
  - Clears `pos`, `len`, the FIFO (pointers and count) and `acc_err`.
  - Sets `first`.
  - `acc` contents are not reset.
  - Reset mid-stripe abandons all partial sums.

## Timing
- **Reset values:** `acc_out_pvld`=0, `acc_out_data`=0, `acc_out_layer_end`=0, `dp2reg_done`=0, `acc_err`=0.
- **Latency:** input beat at edge N is registered at edge N. Accumulator write / FIFO push happens at edge N+1. `acc_out_pvld` rises after edge N+1 when the FIFO was empty.
- **Throughput:** one input beat per cycle, unconditionally. Output sustains one atom per cycle while `acc_out_prdy`=1.
- **Output handshake:**
  - `acc_out_data` and `acc_out_layer_end` are stable while `acc_out_pvld`=1 and `acc_out_prdy`=0.
  - `acc_out_pvld` never drops without a pop.
- **FIFO:** pointers wrap modulo OUT_DEPTH. Full = count==OUT_DEPTH; empty = count==0.

## Configuration
- `CACC_SAT_EN` defined: a sum outside the signed ACC_WIDTH range clamps to the max/min value.
- `CACC_SAT_EN` undefined: the sum wraps, keeping the low ACC_WIDTH bits.
- No other behaviour differs.

## Structure
- Package `cacc_pkg`:
  - pd bit index constants (STRIPE_ST=0, STRIPE_END=1, CHANNEL_END=2, LAYER_END=3).
  - Error bit indices.
  - Sign-extend function.
  - Saturating-add function, which honours `CACC_SAT_EN`.
- Sub-module `cacc_out_fifo`: synchronous valid/ready FIFO of width ATOMK_HALF*ACC_WIDTH+1 and depth OUT_DEPTH. It exposes full/empty plus push/pop.

## Test plan
- **Basic accumulation:** 3 stripes of 4 beats, all lanes = 5, channel_end on the 3rd stripe, prdy=1 → 4 atoms, every lane 15, first `acc_out_pvld` 2 cycles after the 3rd stripe's first beat.
- **Mask and sign:** lane 0 masked, lane 1 = −3 over 2 stripes (len 2) → lane 0 = 0, lane 1 = −6.
- **Saturation:** with `CACC_SAT_EN`, lane 0 = 2^18−1 for 2^14 single-beat stripes, channel_end on the last → lane 0 = 2^31−1. Without the macro → the wrapped value. Stripe length 1 exercises forwarding.
- **Backpressure:** prdy=0 through a 6-beat channel_end stripe (OUT_DEPTH=4) → 4 entries held, `acc_err[2]`=1, entries 1–4 emerge intact when prdy=1.
- **Errors:** a 17-beat stripe (DEPTH=16) → `acc_err[0]`=1. Stripe lengths 4 then 3 in one channel group → `acc_err[1]`=1.
- **Done and reset:** layer_end on the final atom → `dp2reg_done` pulses exactly once, the cycle after its pop. Reset asserted mid-stripe → all outputs 0 next cycle, and the next stripe overwrites.
